// File: rtl/peri_pkg.sv
// peri_pkg: register offsets, TCON bit indices and word type shared by the MIPS peripherals
package peri_pkg;

    typedef logic [31:0] word_t;

    localparam word_t TH_OFS      = 32'h0000_0000;
    localparam word_t TL_OFS      = 32'h0000_0004;
    localparam word_t TCON_OFS    = 32'h0000_0008;
    localparam word_t SYSTICK_OFS = 32'h0000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IF = 2;

endpackage

// File: rtl/peri_prescaler.sv
// peri_prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the last count
module peri_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d;

    // advance while enabled, wrap after the tick, hold while disabled, clear on EN rising
    always_comb begin
        tick  = en && cnt_q == LAST;
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 16'd1;
    end

    // prescale count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/peri_timer.sv
// peri_timer: memory-mapped TH/TL/TCON reloading timer with level irq; SYSTICK built when PERI_SYSTICK_EN is defined
module peri_timer
    import peri_pkg::*;
#(
    parameter int    PRESCALE  = 1,
    parameter word_t BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    word_t      th_q, th_d, tl_q, tl_d, wofs, systick_rd;
    logic [2:0] tcon_q, tcon_d;
    logic       sel_th, sel_tl, sel_tcon, sel_st;
    logic       we_th, we_tl, we_tcon;
    logic       tick, clr, ovf, set_if;

    peri_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (tcon_q[TCON_EN]),
        .clr   (clr),
        .tick  (tick)
    );

`ifdef PERI_SYSTICK_EN
    word_t systick_q, systick_d;

    // free-running cycle counter, independent of EN
    always_comb begin
        systick_d = systick_q + 32'd1;
    end

    // systick register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) systick_q <= '0;
        else        systick_q <= systick_d;
    end

    assign systick_rd = systick_q;
`else
    assign systick_rd = '0;
`endif

    // word-aligned address decode and combinational read mux
    always_comb begin
        wofs     = (addr - BASE_ADDR) & ~32'h3;
        sel_th   = wofs == TH_OFS;
        sel_tl   = wofs == TL_OFS;
        sel_tcon = wofs == TCON_OFS;
`ifdef PERI_SYSTICK_EN
        sel_st   = wofs == SYSTICK_OFS;
`else
        sel_st   = 1'b0;
`endif
        hit      = sel_th | sel_tl | sel_tcon | sel_st;
        rdata    = sel_th ? th_q : sel_tl ? tl_q : sel_tcon ? {29'b0, tcon_q} : sel_st ? systick_rd : '0;
        irq      = tcon_q[TCON_IF] & tcon_q[TCON_IE];
    end

    // next state: software writes beat counting, except the hardware IF set beats a TCON write
    always_comb begin
        we_th   = wr_en & sel_th;
        we_tl   = wr_en & sel_tl;
        we_tcon = wr_en & sel_tcon;
        clr     = we_tcon && wdata[TCON_EN] && !tcon_q[TCON_EN];
        ovf     = tick && tl_q == 32'hFFFF_FFFF;
        set_if  = ovf && tcon_q[TCON_IE] && !we_tl;
        th_d    = we_th ? wdata : th_q;
        tl_d    = we_tl ? wdata : ovf ? th_q : tick ? tl_q + 32'd1 : tl_q;
        tcon_d  = we_tcon ? wdata[2:0] : tcon_q;
        if (set_if) tcon_d[TCON_IF] = 1'b1;
    end

    // timer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

endmodule

// File: tb/tb_peri_timer.sv
// tb_peri_timer: directed checks of peri_timer with PRESCALE=1 (u1) and PRESCALE=4 (u4) on a shared bus
module tb_peri_timer;
    import peri_pkg::*;

    localparam word_t B = 32'h4000_0000;

    logic  clk = 1'b0, reset = 1'b0, wr_en = 1'b0;
    word_t addr = B, wdata = '0;
    word_t rdata1, rdata4;
    logic  hit1, hit4, irq1, irq4;
    int    tests = 0, fails = 0;
    word_t st_exp;

    always #5 clk = ~clk;

    peri_timer #(.PRESCALE(1)) u1 (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rdata(rdata1), .hit(hit1), .irq(irq1)
    );

    peri_timer #(.PRESCALE(4)) u4 (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rdata(rdata4), .hit(hit4), .irq(irq4)
    );

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input word_t ofs, input word_t d);
        addr  = B + ofs;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input word_t ofs);
        addr = B + ofs;
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
`ifdef PERI_SYSTICK_EN
        st_exp = 32'd5;
`else
        st_exp = 32'd0;
`endif
        #1;
        rd(TH_OFS);      chk("rst_th", rdata1, 0);
        rd(TL_OFS);      chk("rst_tl", rdata1, 0);
        rd(TCON_OFS);    chk("rst_tcon", rdata1, 0);
        rd(SYSTICK_OFS); chk("rst_systick", rdata1, 0);
        chk("rst_irq", {31'b0, irq1}, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(5);
        rd(SYSTICK_OFS); chk("systick_5", rdata1, st_exp);

        rst_pulse();
        wr(TH_OFS, 32'hFFFF_FFFC);
        wr(TL_OFS, 32'hFFFF_FFFC);
        wr(TCON_OFS, 32'h3);
        cyc(3);
        rd(TL_OFS);   chk("ovf_pre_tl", rdata1, 32'hFFFF_FFFF);
        chk("ovf_pre_irq", {31'b0, irq1}, 0);
        cyc(1);
        rd(TL_OFS);   chk("ovf_reload_tl", rdata1, 32'hFFFF_FFFC);
        chk("ovf_irq", {31'b0, irq1}, 1);
        rd(TCON_OFS); chk("ovf_tcon", rdata1, 32'h7);
        wr(TCON_OFS, 32'h3);
        chk("clr_if_irq", {31'b0, irq1}, 0);
        cyc(2);
        chk("irq_not_early", {31'b0, irq1}, 0);
        cyc(1);
        chk("irq_again", {31'b0, irq1}, 1);

        rst_pulse();
        wr(TH_OFS, 32'hFFFF_FFFC);
        wr(TL_OFS, 32'hFFFF_FFFC);
        wr(TCON_OFS, 32'h1);
        cyc(4);
        rd(TL_OFS);   chk("noie_tl", rdata1, 32'hFFFF_FFFC);
        rd(TCON_OFS); chk("noie_tcon", rdata1, 32'h1);
        chk("noie_irq", {31'b0, irq1}, 0);

        rst_pulse();
        wr(TL_OFS, 32'h0);
        wr(TCON_OFS, 32'h1);
        cyc(11);
        rd(TL_OFS);   chk("pre4_tl_11", rdata4, 32'd2);
        cyc(1);
        rd(TL_OFS);   chk("pre4_tl_12", rdata4, 32'd3);
        wr(TCON_OFS, 32'h0);
        cyc(10);
        rd(TL_OFS);   chk("pre4_hold", rdata4, 32'd3);

        rst_pulse();
        wr(TH_OFS, 32'hFFFF_FFFC);
        wr(TL_OFS, 32'hFFFF_FFFC);
        wr(TCON_OFS, 32'h3);
        cyc(3);
        wr(TL_OFS, 32'h10);
        rd(TL_OFS);   chk("coll_tl_wr", rdata1, 32'h10);
        rd(TCON_OFS); chk("coll_tl_if", rdata1, 32'h3);
        chk("coll_tl_irq", {31'b0, irq1}, 0);
        wr(TL_OFS, 32'hFFFF_FFFE);
        cyc(1);
        wr(TCON_OFS, 32'h3);
        rd(TCON_OFS); chk("coll_tcon_if", rdata1, 32'h7);
        chk("coll_tcon_irq", {31'b0, irq1}, 1);
        wr(TL_OFS, 32'hFFFF_FFFF);
        wr(TH_OFS, 32'h55);
        rd(TL_OFS);   chk("coll_th_old", rdata1, 32'hFFFF_FFFC);
        rd(TH_OFS);   chk("coll_th_new", rdata1, 32'h55);

        rd(32'h0C); chk("dec_0c_hit", {31'b0, hit1}, 0); chk("dec_0c_rd", rdata1, 0);
        rd(32'h10); chk("dec_10_hit", {31'b0, hit1}, 0); chk("dec_10_rd", rdata1, 0);
        rd(32'h100); chk("dec_out_hit", {31'b0, hit1}, 0);
        rd(32'h06); chk("dec_tl_hit", {31'b0, hit1}, 1);

        @(negedge clk);
        addr = B + TL_OFS;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_tl", rdata1, 0);
        chk("midrst_irq", {31'b0, irq1}, 0);
        #1;
        reset = 1'b1;
        cyc(3);
        rd(TL_OFS);   chk("midrst_no_resume", rdata1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
